dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter and its CPU lane aligner.
package dmem_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_DMA_BURST = 2'd1;
    localparam state_t ST_DMA_DONE  = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEPTH_WORDS_DEFAULT = 512;

endpackage

// File: rtl/dmem_lane_align.sv
// CPU byte-lane logic: byte enables, store data replication, load extraction
// and misalignment detection. Purely combinational.
module dmem_lane_align
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata[{addr_lsb, 3'b000} +: 8];
    assign ld_half = rdata[{addr_lsb[1], 4'b0000} +: 16];

    always_comb begin
        byte_en    = 4'b0000;
        wdata_rep  = 32'h0;
        rdata_ext  = 32'h0;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en   = 4'b0001 << addr_lsb;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = unsigned_ld ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                if (addr_lsb[0]) begin
                    misaligned = 1'b1;
                end else begin
                    byte_en   = 4'b0011 << {addr_lsb[1], 1'b0};
                    wdata_rep = {2{wdata[15:0]}};
                    rdata_ext = unsigned_ld ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
                end
            end
            SZ_WORD: begin
                if (addr_lsb != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    byte_en   = 4'b1111;
                    wdata_rep = wdata;
                    rdata_ext = rdata;
                end
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU accesses in IDLE, DMA bursts of one word
// per cycle, with a starvation limit on CPU grants while DMA is waiting.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX  = 4,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_unsigned,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [7:0]  dma_len,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic        mem_write,
    output logic [3:0]  byte_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [29:0]     WORDS      = 30'(DEPTH_WORDS);
    localparam logic [29:0]     WORD_LAST  = 30'(DEPTH_WORDS - 1);

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [8:0]    beat_cnt;
    logic [29:0]   word_addr;
    logic          burst_we;
    logic          dma_start;
    logic [29:0]   cpu_word;

    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;
    logic          lane_misaligned;

    logic          unused_dma_lsbs;
    assign unused_dma_lsbs = ^dma_addr[1:0];

    dmem_lane_align u_lane (
        .size        (cpu_size),
        .unsigned_ld (cpu_unsigned),
        .addr_lsb    (cpu_addr[1:0]),
        .wdata       (cpu_wdata),
        .rdata       (mem_rdata),
        .byte_en     (lane_be),
        .wdata_rep   (lane_wdata),
        .rdata_ext   (lane_rdata),
        .misaligned  (lane_misaligned)
    );

    // Grants are suppressed while reset is high so requests seen then are ignored.
    assign cpu_gnt   = !reset && (state == ST_IDLE) && cpu_req
                       && !(dma_req && (starve_cnt == STARVE_LIM));
    assign dma_start = !reset && (state == ST_IDLE) && dma_req && !cpu_gnt;
    assign dma_gnt   = !reset && (state == ST_DMA_BURST);
    assign dma_done  = !reset && (state == ST_DMA_DONE);
    assign cpu_err   = cpu_gnt && lane_misaligned;
    assign cpu_word  = cpu_addr[31:2] % WORDS;

    always_comb begin
        mem_write = 1'b0;
        byte_en   = 4'b0000;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        cpu_rdata = 32'h0;
        dma_rdata = 32'h0;
        if (cpu_gnt) begin
            mem_addr = {cpu_word, cpu_addr[1:0]};
            if (!lane_misaligned) begin
                mem_write = cpu_we;
                byte_en   = lane_be;
                mem_wdata = lane_wdata;
                cpu_rdata = lane_rdata;
            end
        end else if (dma_gnt) begin
            mem_write = burst_we;
            byte_en   = 4'b1111;
            mem_addr  = {word_addr, 2'b00};
            mem_wdata = dma_wdata;
            dma_rdata = mem_rdata;
        end
    end

    // A burst counts down its beats; the cycle after the last beat is DMA_DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            beat_cnt   <= 9'd0;
            word_addr  <= 30'd0;
            burst_we   <= 1'b0;
        end else begin
            if (dma_start || !dma_req) begin
                starve_cnt <= '0;
            end else if (cpu_gnt && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (dma_start) begin
                        word_addr <= dma_addr[31:2] % WORDS;
                        burst_we  <= dma_we;
                        beat_cnt  <= (dma_len == 8'd0) ? 9'd256 : {1'b0, dma_len};
                        state     <= ST_DMA_BURST;
                    end
                end
                ST_DMA_BURST: begin
                    word_addr <= (word_addr == WORD_LAST) ? 30'd0 : word_addr + 30'd1;
                    beat_cnt  <= beat_cnt - 9'd1;
                    if (beat_cnt == 9'd1) begin
                        state <= ST_DMA_DONE;
                    end
                end
                ST_DMA_DONE: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 512-word memory on the mem port.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_unsigned;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic [7:0]  dma_len;
    logic        dma_gnt, dma_done;
    logic [31:0] dma_rdata;
    logic        mem_write;
    logic [3:0]  byte_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests = 0;
    int failures = 0;

    logic [31:0] mem [512];
    logic        tb_clear;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_done(dma_done),
        .mem_write(mem_write), .byte_en(byte_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) mem[mem_addr[10:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic applyStimulus(input logic creq, input logic cwe, input logic [1:0] csize,
                                 input logic cuns, input logic [31:0] caddr, input logic [31:0] cwdata,
                                 input logic dreq, input logic dwe, input logic [31:0] daddr,
                                 input logic [7:0] dlen, input logic [31:0] dwdata);
        @(negedge clk);
        cpu_req = creq; cpu_we = cwe; cpu_size = csize; cpu_unsigned = cuns;
        cpu_addr = caddr; cpu_wdata = cwdata;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_len = dlen; dma_wdata = dwdata;
        #1;
    endtask

    task automatic cpuStep(input logic cwe, input logic [1:0] csize, input logic cuns,
                           input logic [31:0] caddr, input logic [31:0] cwdata);
        applyStimulus(1'b1, cwe, csize, cuns, caddr, cwdata, 1'b0, 1'b0, 32'h0, 8'd0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    logic [31:0] burst_addr [4];
    logic        exp_cgnt [9];
    logic        exp_dgnt [9];
    logic        exp_done [9];

    initial begin
        burst_addr = '{32'h7F8, 32'h7FC, 32'h000, 32'h004};
        exp_cgnt   = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
        exp_dgnt   = '{0, 0, 0, 0, 0, 1, 1, 0, 0};
        exp_done   = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

        // Reset with both requesters active: nothing may be granted
        tb_clear = 1'b1; reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = SZ_WORD; cpu_unsigned = 1'b0;
        cpu_addr = 32'h40; cpu_wdata = 32'h5555_5555;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0; dma_len = 8'd1; dma_wdata = 32'h0;
        @(negedge clk); @(negedge clk); #1;
        checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        checkOutput("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_byte_en", 32'(byte_en), 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0; tb_clear = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
        #1;
        checkOutput("post_rst_done", 32'(dma_done), 32'd0);
        checkOutput("post_rst_dgnt", 32'(dma_gnt), 32'd0);

        // Byte store replication, then word readback
        cpuStep(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0000_00AB);
        checkOutput("sb_gnt", 32'(cpu_gnt), 32'd1);
        checkOutput("sb_be", 32'(byte_en), 32'h8);
        checkOutput("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_we", 32'(mem_write), 32'd1);
        checkOutput("sb_addr", mem_addr, 32'h13);
        cpuStep(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        checkOutput("sb_readback", cpu_rdata, 32'hAB00_0000);
        cpuStep(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000_1234);
        checkOutput("sh_be", 32'(byte_en), 32'hC);
        checkOutput("sh_wdata", mem_wdata, 32'h1234_1234);
        cpuStep(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        checkOutput("sh_readback", cpu_rdata, 32'h1234_0000);

        // Half/byte load extraction
        cpuStep(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h8001_7FFF);
        checkOutput("sw_be", 32'(byte_en), 32'hF);
        cpuStep(1'b0, SZ_HALF, 1'b0, 32'h22, 32'h0);
        checkOutput("lh_signed", cpu_rdata, 32'hFFFF_8001);
        cpuStep(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0);
        checkOutput("lh_unsigned", cpu_rdata, 32'h0000_8001);
        cpuStep(1'b0, SZ_BYTE, 1'b0, 32'h21, 32'h0);
        checkOutput("lb_pos", cpu_rdata, 32'h0000_007F);
        cpuStep(1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0);
        checkOutput("lb_neg", cpu_rdata, 32'hFFFF_FF80);

        // Misaligned accesses
        cpuStep(1'b1, SZ_WORD, 1'b0, 32'h102, 32'hDEAD_BEEF);
        checkOutput("mis_gnt", 32'(cpu_gnt), 32'd1);
        checkOutput("mis_err", 32'(cpu_err), 32'd1);
        checkOutput("mis_we", 32'(mem_write), 32'd0);
        checkOutput("mis_be", 32'(byte_en), 32'd0);
        checkOutput("mis_rdata", cpu_rdata, 32'h0);
        cpuStep(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
        checkOutput("mis_readback", cpu_rdata, 32'h0);
        checkOutput("aligned_err", 32'(cpu_err), 32'd0);
        cpuStep(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
        checkOutput("size11_err", 32'(cpu_err), 32'd1);
        cpuStep(1'b0, SZ_HALF, 1'b0, 32'h21, 32'h0);
        checkOutput("half_odd_err", 32'(cpu_err), 32'd1);

        // No request: memory port quiet
        applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h44, 32'h0, 1'b0, 1'b0, 32'h0, 8'd0, 32'h0);
        checkOutput("idle_gnt", 32'(cpu_gnt), 32'd0);
        checkOutput("idle_addr", mem_addr, 32'h0);
        checkOutput("idle_rdata", cpu_rdata, 32'h0);

        // DMA write burst wrapping past the top of memory
        applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h7F8, 8'd4, 32'h0);
        checkOutput("latch_dgnt", 32'(dma_gnt), 32'd0);
        checkOutput("latch_be", 32'(byte_en), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 8'd0,
                          32'h1111_0000 + 32'(i));
            checkOutput("beat_dgnt", 32'(dma_gnt), 32'd1);
            checkOutput("beat_addr", mem_addr, burst_addr[i]);
            checkOutput("beat_we", 32'(mem_write), 32'd1);
            checkOutput("beat_be", 32'(byte_en), 32'hF);
        end
        applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 8'd0, 32'h0);
        checkOutput("done_pulse", 32'(dma_done), 32'd1);
        checkOutput("done_dgnt", 32'(dma_gnt), 32'd0);
        applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 8'd0, 32'h0);
        checkOutput("done_once", 32'(dma_done), 32'd0);
        cpuStep(1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        checkOutput("wrap_word", cpu_rdata, 32'h1111_0002);
        cpuStep(1'b0, SZ_WORD, 1'b0, 32'h7FC, 32'h0);
        checkOutput("top_word", cpu_rdata, 32'h1111_0001);

        // Contention: both requesters held high
        for (int s = 0; s < 9; s++) begin
            applyStimulus(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h7F8, 32'h0, 1'b1, 1'b0, 32'h7F8, 8'd2, 32'h0);
            checkOutput("cont_cgnt", 32'(cpu_gnt), 32'(exp_cgnt[s]));
            checkOutput("cont_dgnt", 32'(dma_gnt), 32'(exp_dgnt[s]));
            checkOutput("cont_done", 32'(dma_done), 32'(exp_done[s]));
            if (s == 0) checkOutput("cont_cpu_rd", cpu_rdata, 32'h1111_0000);
            if (s == 5) checkOutput("cont_dma_rd0", dma_rdata, 32'h1111_0000);
            if (s == 6) checkOutput("cont_dma_rd1", dma_rdata, 32'h1111_0001);
        end
        applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 8'd0, 32'h0);

        // Reset in the middle of an 8-beat burst
        applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 8'd8, 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 8'd0,
                          32'hCAFE_0000 + 32'(i));
            checkOutput("abort_beat_addr", mem_addr, 32'h200 + 32'(4 * i));
        end
        @(negedge clk);
        reset = 1'b1; dma_wdata = 32'hCAFE_0002;
        #1;
        checkOutput("abort_outs", {26'h0, dma_gnt, dma_done, mem_write, cpu_gnt, cpu_err, |byte_en},
                    32'h0);
        checkOutput("abort_addr", mem_addr, 32'h0);
        checkOutput("abort_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort_idle_dgnt", 32'(dma_gnt), 32'd0);
        checkOutput("abort_idle_done", 32'(dma_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 8'd0, 32'h0);
            checkOutput("abort_no_done", 32'(dma_done | dma_gnt), 32'd0);
        end
        cpuStep(1'b0, SZ_WORD, 1'b0, 32'h204, 32'h0);
        checkOutput("abort_beat1_mem", cpu_rdata, 32'hCAFE_0001);
        cpuStep(1'b0, SZ_WORD, 1'b0, 32'h208, 32'h0);
        checkOutput("abort_beat2_mem", cpu_rdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
